// File: rtl/axo_misalign_splitter.sv
// axo_misalign_splitter
// Sits in front of a naturally aligned 32-bit RAM. Aligned requests are
// forwarded combinationally; misaligned halfword/word requests are broken into
// sequential byte accesses, and read bytes are reassembled into one response.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   cpu_addr/asize/re/we/wdata    upstream request (held until cpu_ready)
//   cpu_rdata/ready/error         upstream response
//   mem_addr/asize/re/we/wdata    downstream request
//   mem_rdata/ready/error         downstream response
module axo_misalign_splitter #(
    parameter int alen         = 32,
    parameter bit enable_split = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [alen-1:0] cpu_addr,
    input  logic [1:0]      cpu_asize,
    input  logic            cpu_re,
    input  logic            cpu_we,
    input  logic [31:0]     cpu_wdata,
    output logic [31:0]     cpu_rdata,
    output logic            cpu_ready,
    output logic            cpu_error,
    output logic [alen-1:0] mem_addr,
    output logic [1:0]      mem_asize,
    output logic            mem_re,
    output logic            mem_we,
    output logic [31:0]     mem_wdata,
    input  logic [31:0]     mem_rdata,
    input  logic            mem_ready,
    input  logic            mem_error
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SPLIT = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [alen-1:0]   r_base;
    logic              r_re;
    logic              r_we;
    logic [31:0]       r_wdata;
    logic [1:0]        r_last;
    logic [1:0]        r_cnt;
    logic [31:0]       r_buf;
    logic [31:0]       r_ecode;
    logic              r_eflag;

    logic              w_misaligned;
    logic [alen-1:0]   w_cnt_ext;
    logic [7:0]        w_wbyte;

    function automatic logic is_misaligned(input logic       req,
                                           input logic [1:0] asize,
                                           input logic [1:0] alo);
        logic m;
        m = 1'b0;
        if (enable_split && req) begin
            if (asize == 2'd1 && alo[0])
                m = 1'b1;
            else if (asize == 2'd2 && alo != 2'd0)
                m = 1'b1;
        end
        return m;
    endfunction

    assign w_misaligned = is_misaligned(cpu_re | cpu_we, cpu_asize, cpu_addr[1:0]);
    assign w_cnt_ext    = {{(alen-2){1'b0}}, r_cnt};
    assign w_wbyte      = r_wdata[r_cnt*8 +: 8];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_base  <= '0;
            r_re    <= 1'b0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_last  <= '0;
            r_cnt   <= '0;
            r_buf   <= '0;
            r_ecode <= '0;
            r_eflag <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (w_misaligned) begin
                        r_base  <= cpu_addr;
                        r_re    <= cpu_re;
                        r_we    <= cpu_we;
                        r_wdata <= cpu_wdata;
                        r_last  <= (cpu_asize == 2'd1) ? 2'd1 : 2'd3;
                        r_cnt   <= '0;
                    end
                end
                ST_SPLIT: begin
                    if (mem_ready) begin
                        if (mem_error) begin
                            // Abort: remaining bytes are never issued.
                            r_ecode <= mem_rdata;
                            r_eflag <= 1'b1;
                        end else begin
                            r_buf[r_cnt*8 +: 8] <= mem_rdata[7:0];
                            if (r_cnt != r_last)
                                r_cnt <= r_cnt + 2'd1;
                        end
                    end
                end
                ST_RESP: begin
                    r_eflag <= 1'b0;
                    r_ecode <= '0;
                    r_cnt   <= '0;
                    r_buf   <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        cpu_rdata   = '0;
        cpu_ready   = 1'b0;
        cpu_error   = 1'b0;
        mem_addr    = '0;
        mem_asize   = '0;
        mem_re      = 1'b0;
        mem_we      = 1'b0;
        mem_wdata   = '0;
        // Reset is asynchronous, so outputs are gated directly rather than
        // waiting for the state register to settle.
        if (!rst) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_misaligned) begin
                        w_state_nxt = ST_SPLIT;
                    end else begin
                        mem_addr  = cpu_addr;
                        mem_asize = cpu_asize;
                        mem_re    = cpu_re;
                        mem_we    = cpu_we;
                        mem_wdata = cpu_wdata;
                        cpu_rdata = mem_rdata;
                        cpu_ready = mem_ready;
                        cpu_error = mem_error;
                    end
                end
                ST_SPLIT: begin
                    mem_addr  = r_base + w_cnt_ext;
                    mem_asize = 2'd0;
                    mem_re    = r_re;
                    mem_we    = r_we;
                    mem_wdata = {4{w_wbyte}};
                    if (mem_ready && (mem_error || r_cnt == r_last))
                        w_state_nxt = ST_RESP;
                end
                ST_RESP: begin
                    cpu_ready   = 1'b1;
                    cpu_error   = r_eflag;
                    cpu_rdata   = r_eflag ? r_ecode : r_buf;
                    w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axo_misalign_splitter.sv
module tb_axo_misalign_splitter;

    logic        clk;
    logic        rst;
    logic [31:0] cpu_addr;
    logic [1:0]  cpu_asize;
    logic        cpu_re;
    logic        cpu_we;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        cpu_error;
    logic [31:0] mem_addr;
    logic [1:0]  mem_asize;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        mem_error;

    // Pass-through-only instance, fed from fixed downstream responses.
    logic [31:0] ns_cpu_rdata;
    logic        ns_cpu_ready;
    logic        ns_cpu_error;
    logic [31:0] ns_mem_addr;
    logic [1:0]  ns_mem_asize;
    logic        ns_mem_re;
    logic        ns_mem_we;
    logic [31:0] ns_mem_wdata;
    logic [31:0] ns_mem_rdata;
    logic        ns_mem_ready;
    logic        ns_mem_error;

    int total = 0;
    int bad   = 0;

    axo_misalign_splitter #(.alen(32), .enable_split(1'b1)) u_dut (
        .clk(clk), .rst(rst),
        .cpu_addr(cpu_addr), .cpu_asize(cpu_asize), .cpu_re(cpu_re), .cpu_we(cpu_we),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_error(cpu_error),
        .mem_addr(mem_addr), .mem_asize(mem_asize), .mem_re(mem_re), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_error(mem_error)
    );

    axo_misalign_splitter #(.alen(32), .enable_split(1'b0)) u_dut_ns (
        .clk(clk), .rst(rst),
        .cpu_addr(cpu_addr), .cpu_asize(cpu_asize), .cpu_re(cpu_re), .cpu_we(cpu_we),
        .cpu_wdata(cpu_wdata), .cpu_rdata(ns_cpu_rdata), .cpu_ready(ns_cpu_ready), .cpu_error(ns_cpu_error),
        .mem_addr(ns_mem_addr), .mem_asize(ns_mem_asize), .mem_re(ns_mem_re), .mem_we(ns_mem_we),
        .mem_wdata(ns_mem_wdata), .mem_rdata(ns_mem_rdata), .mem_ready(ns_mem_ready), .mem_error(ns_mem_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- downstream memory model ----------------
    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  asize;
        logic        re;
        logic        we;
        logic [31:0] wdata;
    } acc_t;

    logic [7:0]  mem [0:4095];
    acc_t        acc_log[$];
    int          wait_cfg = 0;
    int          wcnt     = 0;
    logic        err_en   = 1'b0;
    logic [31:0] err_addr = '0;
    logic [31:0] err_code = '0;
    logic [11:0] ma;
    logic [31:0] rd_word;

    always_comb begin
        ma = mem_addr[11:0];
        case (mem_asize)
            2'd0:    rd_word = {24'h0, mem[ma]};
            2'd1:    rd_word = {16'h0, mem[ma + 12'd1], mem[ma]};
            default: rd_word = {mem[ma + 12'd3], mem[ma + 12'd2], mem[ma + 12'd1], mem[ma]};
        endcase
        mem_ready = (mem_re | mem_we) && (wcnt == wait_cfg);
        mem_error = mem_ready && err_en && (mem_addr == err_addr);
        mem_rdata = mem_error ? err_code : rd_word;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt <= 0;
        end else begin
            if ((mem_re | mem_we) && !mem_ready)
                wcnt <= wcnt + 1;
            else
                wcnt <= 0;
            if (mem_ready) begin
                acc_log.push_back({mem_addr, mem_asize, mem_re, mem_we, mem_wdata});
                if (mem_we && !mem_error) begin
                    mem[ma] <= mem_wdata[7:0];
                    if (mem_asize != 2'd0) mem[ma + 12'd1] <= mem_wdata[15:8];
                    if (mem_asize == 2'd2) begin
                        mem[ma + 12'd2] <= mem_wdata[23:16];
                        mem[ma + 12'd3] <= mem_wdata[31:24];
                    end
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_req(input string tag, input logic [31:0] a, input logic [1:0] sz,
                          input logic re, input logic we, input logic [31:0] wd,
                          output int cyc, output logic [31:0] rd, output logic er,
                          output logic [1:0] first_sz);
        logic got;
        @(posedge clk); #1;
        cpu_addr = a; cpu_asize = sz; cpu_re = re; cpu_we = we; cpu_wdata = wd;
        cyc = 0; got = 1'b0; rd = '0; er = 1'b0; first_sz = '0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) first_sz = mem_asize;
            if (cpu_ready) begin
                got = 1'b1;
                rd  = cpu_rdata;
                er  = cpu_error;
            end
        end
        chk({tag, "_ready_seen"}, 64'(got), 64'd1);
        @(posedge clk); #1;
        cpu_re = 1'b0; cpu_we = 1'b0;
        @(negedge clk);
        chk({tag, "_ready_single"}, 64'(cpu_ready), 64'd0);
    endtask

    int          cyc;
    logic [31:0] rd;
    logic        er;
    logic [1:0]  fsz;
    int          rdy_cnt;

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[12'h010] = 8'hEF; mem[12'h011] = 8'hBE; mem[12'h012] = 8'hAD; mem[12'h013] = 8'hDE;
        mem[12'h021] = 8'h34; mem[12'h022] = 8'h12;
        mem[12'h3FD] = 8'h11; mem[12'h3FE] = 8'h22; mem[12'h3FF] = 8'h33;
        mem[12'hFFF] = 8'h78; mem[12'h000] = 8'h56;
        ns_mem_rdata = 32'h0BAD0BAD; ns_mem_ready = 1'b1; ns_mem_error = 1'b1;

        // Reset with a request already on the bus: everything must read zero.
        rst = 1'b1;
        cpu_addr = 32'h10; cpu_asize = 2'd2; cpu_re = 1'b1; cpu_we = 1'b0; cpu_wdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("rst_mem_addr", 64'(mem_addr), 64'h0);
        chk("rst_mem_ctl", 64'({mem_re, mem_we, mem_asize}), 64'h0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'h0);
        chk("rst_cpu_out", 64'({cpu_ready, cpu_error, cpu_rdata}), 64'h0);
        @(posedge clk); #1;
        rst = 1'b0; cpu_re = 1'b0;

        // Aligned word read, same-cycle response.
        acc_log.delete();
        do_req("aligned", 32'h10, 2'd2, 1'b1, 1'b0, 32'h0, cyc, rd, er, fsz);
        chk("aligned_cyc", 64'(cyc), 64'd1);
        chk("aligned_rdata", 64'(rd), 64'hDEADBEEF);
        chk("aligned_asize", 64'(fsz), 64'd2);
        chk("aligned_err", 64'(er), 64'd0);

        // Misaligned half read.
        acc_log.delete();
        do_req("half", 32'h21, 2'd1, 1'b1, 1'b0, 32'h0, cyc, rd, er, fsz);
        chk("half_cyc", 64'(cyc), 64'd4);
        chk("half_rdata", 64'(rd), 64'h00001234);
        chk("half_nacc", 64'(acc_log.size()), 64'd2);
        chk("half_acc0", 64'({acc_log[0].addr, acc_log[0].asize, acc_log[0].re, acc_log[0].we}), {32'h0, 32'h21, 2'd0, 1'b1, 1'b0} >> 0);
        chk("half_acc1_addr", 64'(acc_log[1].addr), 64'h22);

        // Misaligned word write, then aligned readback.
        acc_log.delete();
        do_req("wwr", 32'h43, 2'd2, 1'b0, 1'b1, 32'hA1B2C3D4, cyc, rd, er, fsz);
        chk("wwr_cyc", 64'(cyc), 64'd6);
        chk("wwr_nacc", 64'(acc_log.size()), 64'd4);
        chk("wwr_a0", 64'({acc_log[0].addr, acc_log[0].wdata}), {32'h43, 32'hD4D4D4D4});
        chk("wwr_a1", 64'({acc_log[1].addr, acc_log[1].wdata}), {32'h44, 32'hC3C3C3C3});
        chk("wwr_a2", 64'({acc_log[2].addr, acc_log[2].wdata}), {32'h45, 32'hB2B2B2B2});
        chk("wwr_a3", 64'({acc_log[3].addr, acc_log[3].wdata}), {32'h46, 32'hA1A1A1A1});
        chk("wwr_a3_ctl", 64'({acc_log[3].asize, acc_log[3].re, acc_log[3].we}), 64'b0001);
        do_req("rdback", 32'h44, 2'd2, 1'b1, 1'b0, 32'h0, cyc, rd, er, fsz);
        chk("rdback_rdata", 64'(rd), 64'h00A1B2C3);

        // Error on byte 2 of a misaligned word read.
        acc_log.delete();
        err_en = 1'b1; err_addr = 32'h3FF; err_code = 32'hE000_0005;
        do_req("err", 32'h3FD, 2'd2, 1'b1, 1'b0, 32'h0, cyc, rd, er, fsz);
        err_en = 1'b0;
        chk("err_cyc", 64'(cyc), 64'd5);
        chk("err_flag", 64'(er), 64'd1);
        chk("err_rdata", 64'(rd), 64'hE0000005);
        chk("err_nacc", 64'(acc_log.size()), 64'd3);

        // Wrap-around with two wait states per byte.
        acc_log.delete();
        wait_cfg = 2;
        do_req("wrap", 32'hFFFF_FFFF, 2'd1, 1'b1, 1'b0, 32'h0, cyc, rd, er, fsz);
        wait_cfg = 0;
        chk("wrap_cyc", 64'(cyc), 64'd8);
        chk("wrap_rdata", 64'(rd), 64'h00005678);
        chk("wrap_nacc", 64'(acc_log.size()), 64'd2);
        chk("wrap_a0", 64'(acc_log[0].addr), 64'hFFFFFFFF);
        chk("wrap_a1", 64'(acc_log[1].addr), 64'h0);

        // Reset during the second byte of a split.
        @(posedge clk); #1;
        cpu_addr = 32'h21; cpu_asize = 2'd1; cpu_re = 1'b1; cpu_we = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_pre_addr", 64'(mem_addr), 64'h22);
        chk("midrst_pre_re", 64'(mem_re), 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("midrst_drop", 64'({mem_re, mem_we, cpu_ready}), 64'd0);
        rdy_cnt = 0;
        @(posedge clk); #1;
        rst = 1'b0; cpu_re = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (cpu_ready) rdy_cnt++;
        end
        chk("midrst_no_ready", 64'(rdy_cnt), 64'd0);
        do_req("post_rst", 32'h10, 2'd2, 1'b1, 1'b0, 32'h0, cyc, rd, er, fsz);
        chk("post_rst_cyc", 64'(cyc), 64'd1);
        chk("post_rst_rdata", 64'(rd), 64'hDEADBEEF);

        // Splitting disabled: misaligned half goes straight through.
        @(posedge clk); #1;
        cpu_addr = 32'h21; cpu_asize = 2'd1; cpu_re = 1'b1; cpu_we = 1'b0;
        @(negedge clk);
        chk("ns_mem_req", 64'({ns_mem_addr, ns_mem_asize, ns_mem_re, ns_mem_we}), {32'h21, 2'd1, 1'b1, 1'b0});
        chk("ns_cpu_resp", 64'({ns_cpu_ready, ns_cpu_error, ns_cpu_rdata}), {1'b1, 1'b1, 32'h0BAD0BAD});
        @(posedge clk); #1;
        cpu_re = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
